// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: 2-flop line synchronizer, per-bit cycle counter with
// mid-bit sampling, one-cycle valid / framing-error strobes.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_framing_error,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [DATA_BITS-1:0]   shift, shift_nxt;
  logic [DATA_BITS-1:0]   data_nxt;
  logic                   valid_nxt, ferr_nxt, busy_nxt;
  logic                   rx_p0, rx_p1;
  logic                   rx_s;

  // Stage p0/p1: metastability synchronizer, idles high
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Frame FSM: every decision is taken on the synchronized line only
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = o_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    busy_nxt  = o_busy;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_M1) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
          if (idx == LAST_IDX) state_nxt = STOP;
          else                 idx_nxt   = idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_M1) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK_WAIT;
          end
        end
      end
      BREAK_WAIT: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      o_data          <= '0;
      o_valid         <= 1'b0;
      o_framing_error <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      idx             <= idx_nxt;
      o_data          <= data_nxt;
      o_valid         <= valid_nxt;
      o_framing_error <= ferr_nxt;
      o_busy          <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized bench for uart_receiver; expectations come from a
// line-history model that samples the driven i_rx at the mid-bit instants.
module tb_uart_receiver;
  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int LAT = 2 + H + 9 * C + 1;
  localparam int N   = 16384;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid, o_framing_error, o_busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int both_cnt = 0;
  int dbl_cnt = 0;
  int good_frames = 0;
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;
  logic [7:0] exp_data = 8'h00;

  logic       rx_h    [N];
  logic       valid_h [N];
  logic       ferr_h  [N];
  logic       busy_h  [N];
  logic [7:0] data_h  [N];
  int         sb_e [$];

  uart_receiver #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_rx(i_rx),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_framing_error(o_framing_error),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < N) begin
      rx_h[cyc]    = i_rx;
      valid_h[cyc] = o_valid;
      ferr_h[cyc]  = o_framing_error;
      busy_h[cyc]  = o_busy;
      data_h[cyc]  = o_data;
    end
    if (o_valid === 1'b1 && o_framing_error === 1'b1) both_cnt++;
    if ((o_valid === 1'b1 && prev_v) || (o_framing_error === 1'b1 && prev_f)) dbl_cnt++;
    prev_v = (o_valid === 1'b1);
    prev_f = (o_framing_error === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference: the byte a receiver must recover from the line level at each mid-bit instant.
  function automatic logic [7:0] model_byte(input int e);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = rx_h[e + H + (k + 1) * C];
    return r;
  endfunction

  function automatic int count_win(input int sel, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) begin
      if (i >= 0 && i < N) begin
        if (sel == 0 && valid_h[i] === 1'b1) n++;
        if (sel == 1 && ferr_h[i]  === 1'b1) n++;
        if (sel == 2 && busy_h[i]  === 1'b1) n++;
      end
    end
    return n;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop, output int e);
    i_rx = 1'b0;
    e = cyc;
    tick(C);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      tick(C);
    end
    i_rx = stop;
    tick(C);
  endtask

  task automatic check_frame(input string tag, input int e);
    int x;
    logic [7:0] m;
    x = e + LAT;
    while (cyc < x + 3) tick(1);
    m = model_byte(e);
    chk({tag, ".valid"},      32'(valid_h[x]),     32'd1);
    chk({tag, ".data"},       32'(data_h[x]),      32'(m));
    chk({tag, ".pre_valid"},  32'(valid_h[x - 1]), 32'd0);
    chk({tag, ".post_valid"}, 32'(valid_h[x + 1]), 32'd0);
    chk({tag, ".busy_fall"},  32'(busy_h[x]),      32'd0);
    chk({tag, ".busy_pre"},   32'(busy_h[x - 1]),  32'd1);
    exp_data = m;
    good_frames++;
  endtask

  initial begin
    int e, e1, e2, r, s, gap;
    logic [7:0] b;

    // Reset state
    i_reset = 1'b0;
    i_rx    = 1'b1;
    tick(3);
    chk("rst.data",  32'(o_data),          32'h00);
    chk("rst.valid", 32'(o_valid),         32'd0);
    chk("rst.ferr",  32'(o_framing_error), 32'd0);
    chk("rst.busy",  32'(o_busy),          32'd0);

    // Idle line
    i_reset = 1'b1;
    s = cyc;
    tick(100);
    chk("idle.data",  32'(o_data), 32'(exp_data));
    chk("idle.valid", count_win(0, s, cyc - 1), 0);
    chk("idle.ferr",  count_win(1, s, cyc - 1), 0);
    chk("idle.busy",  count_win(2, s, cyc - 1), 0);

    // Directed bytes, including all-zero and all-one payloads
    send_frame(8'hF0, 1'b1, e); tick(5); check_frame("f0", e);
    send_frame(8'h55, 1'b1, e); tick(5); check_frame("55", e);
    send_frame(8'h00, 1'b1, e); tick(5); check_frame("00", e);
    send_frame(8'hFF, 1'b1, e); tick(5); check_frame("ff", e);

    // Start-bit glitch of 4 cycles
    e = cyc;
    i_rx = 1'b0;
    tick(4);
    i_rx = 1'b1;
    tick(20);
    chk("glitch.busy_on",  32'(busy_h[e + 3]),  32'd1);
    chk("glitch.busy_off", 32'(busy_h[e + 11]), 32'd0);
    chk("glitch.valid",    count_win(0, e, cyc - 1), 0);
    chk("glitch.ferr",     count_win(1, e, cyc - 1), 0);
    chk("glitch.data",     32'(o_data), 32'(exp_data));

    // Framing error followed by a 50-cycle break
    send_frame(8'hA5, 1'b0, e);
    tick(50);
    r = cyc;
    i_rx = 1'b1;
    tick(10);
    chk("ferr.pulse",     32'(ferr_h[e + LAT]), 32'd1);
    chk("ferr.count",     count_win(1, e, cyc - 1), 1);
    chk("ferr.valid",     count_win(0, e, cyc - 1), 0);
    chk("ferr.data",      32'(o_data), 32'(exp_data));
    chk("ferr.busy_hold", 32'(busy_h[r + 2]), 32'd1);
    chk("ferr.busy_off",  32'(busy_h[r + 3]), 32'd0);
    send_frame(8'h3C, 1'b1, e); tick(5); check_frame("3c", e);

    // Back-to-back frames
    send_frame(8'h12, 1'b1, e1);
    send_frame(8'h34, 1'b1, e2);
    tick(5);
    check_frame("b2b1", e1);
    check_frame("b2b2", e2);
    chk("b2b.count", count_win(0, e1, e2 + LAT + 2), 2);
    chk("b2b.spacing_valid", 32'(valid_h[e1 + LAT + 160]), 32'd1);

    // Reset during data bit 3 aborts the frame
    b = 8'h6B;
    e = cyc;
    i_rx = 1'b0;
    tick(C);
    for (int k = 0; k < 3; k++) begin
      i_rx = b[k];
      tick(C);
    end
    i_rx = b[3];
    tick(8);
    i_reset = 1'b0;
    i_rx = 1'b1;
    exp_data = 8'h00;
    tick(1);
    chk("mrst.valid", 32'(o_valid), 32'd0);
    chk("mrst.busy",  32'(o_busy),  32'd0);
    tick(4);
    i_reset = 1'b1;
    tick(30);
    chk("mrst.data",   32'(o_data), 32'(exp_data));
    chk("mrst.nostrb", count_win(0, e, cyc - 1), 0);
    send_frame(8'hC3, 1'b1, e); tick(5); check_frame("c3", e);
    send_frame(8'hF0, 1'b1, e); tick(5); check_frame("loop_f0", e);

    // Random bytes with random idle gaps (zero gap = back-to-back)
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, e);
      sb_e.push_back(e);
      gap = $urandom_range(0, 25);
      if (gap > 0) tick(gap);
    end
    tick(5);
    while (sb_e.size() > 0) begin
      e = sb_e.pop_front();
      check_frame("rand", e);
    end

    // Global strobe properties
    chk("all.valid_count", count_win(0, 0, cyc - 1), good_frames);
    chk("all.no_overlap",  both_cnt, 0);
    chk("all.single_cyc",  dbl_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
